scorehand: RTL and testbench



---
 rtl/scorehand.sv | 106 ++++++++++
 tb/tb_scorehand.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/scorehand.sv
// Baccarat hand scorer: three card codes -> total mod 10, bad-code flag, optional 1-cycle register.
// Optional `natural` output (two-card 8/9 with no third card) enabled by SCOREHAND_NATURAL_EN.

module scorehand_card (
  input  logic [3:0] code_i,
  output logic [3:0] val_o,
  output logic       bad_o
);
  // 10..13 are zero-valued court cards, 14/15 are illegal and also score zero.
  always_comb begin
    val_o = '0;
    bad_o = 1'b0;
    if (code_i <= 4'd9) val_o = code_i;
    else if (code_i >= 4'd14) bad_o = 1'b1;
  end
endmodule

module scorehand #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] card1,
  input  logic [3:0] card2,
  input  logic [3:0] card3,
  output logic [3:0] total,
  output logic       out_valid,
  output logic       bad_card
`ifdef SCOREHAND_NATURAL_EN
  , output logic     natural
`endif
);
  localparam int NUM_CARDS = 3;

  logic [NUM_CARDS-1:0][3:0] card, val;
  logic [NUM_CARDS-1:0]      bad;
  logic [4:0]                sum, sum1;
  logic [3:0]                total_d;
  logic                      bad_d;

  assign card = {card3, card2, card1};

  for (genvar i = 0; i < NUM_CARDS; i++) begin : g_card
    scorehand_card u_card (.code_i(card[i]), .val_o(val[i]), .bad_o(bad[i]));
  end

  // Sum is at most 27, so two conditional subtracts of 10 complete the mod.
  assign sum     = 5'(val[0]) + 5'(val[1]) + 5'(val[2]);
  assign sum1    = (sum  >= 5'd10) ? sum  - 5'd10 : sum;
  assign total_d = 4'((sum1 >= 5'd10) ? sum1 - 5'd10 : sum1);
  assign bad_d   = |bad;

`ifdef SCOREHAND_NATURAL_EN
  logic [4:0] pair;
  logic [3:0] pair_mod;
  logic       nat_d;

  assign pair     = 5'(val[0]) + 5'(val[1]);
  assign pair_mod = 4'((pair >= 5'd10) ? pair - 5'd10 : pair);
  assign nat_d    = (pair_mod >= 4'd8) && (card3 == 4'd0);
`endif

  if (OUT_REG) begin : g_reg
    logic [3:0] total_q;
    logic       bad_q, vld_q;
`ifdef SCOREHAND_NATURAL_EN
    logic       nat_q;
`endif

    // Results hold across idle cycles; only the valid bit follows in_valid.
    always_ff @(posedge clk) begin
      if (reset) begin
        total_q <= '0;
        bad_q   <= 1'b0;
        vld_q   <= 1'b0;
`ifdef SCOREHAND_NATURAL_EN
        nat_q   <= 1'b0;
`endif
      end else begin
        vld_q <= in_valid;
        if (in_valid) begin
          total_q <= total_d;
          bad_q   <= bad_d;
`ifdef SCOREHAND_NATURAL_EN
          nat_q   <= nat_d;
`endif
        end
      end
    end

    assign total     = total_q;
    assign bad_card  = bad_q;
    assign out_valid = vld_q;
`ifdef SCOREHAND_NATURAL_EN
    assign natural   = nat_q;
`endif
  end else begin : g_comb
    assign total     = total_d;
    assign bad_card  = bad_d;
    assign out_valid = in_valid;
`ifdef SCOREHAND_NATURAL_EN
    assign natural   = nat_d;
`endif
  end
endmodule

// File: tb/tb_scorehand.sv
// Scoreboard bench for scorehand (OUT_REG=1): stimulus pushes expected results, monitor pops on out_valid.

module tb_scorehand;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] card1, card2, card3;
  logic [3:0] total;
  logic       out_valid, bad_card;
  logic       nat_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] c1, c2, c3;
    logic [3:0] tot;
    logic       bad;
    logic       nat;
  } vec_t;

  vec_t exp_q[$];

  always #5 clk = ~clk;

`ifdef SCOREHAND_NATURAL_EN
  scorehand #(.OUT_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .card1(card1), .card2(card2), .card3(card3),
    .total(total), .out_valid(out_valid), .bad_card(bad_card), .natural(nat_out)
  );
`else
  scorehand #(.OUT_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .card1(card1), .card2(card2), .card3(card3),
    .total(total), .out_valid(out_valid), .bad_card(bad_card)
  );
  assign nat_out = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk($sformatf("total[%0d,%0d,%0d]", e.c1, e.c2, e.c3), int'(total), int'(e.tot));
        chk($sformatf("bad[%0d,%0d,%0d]", e.c1, e.c2, e.c3), int'(bad_card), int'(e.bad));
`ifdef SCOREHAND_NATURAL_EN
        chk($sformatf("natural[%0d,%0d,%0d]", e.c1, e.c2, e.c3), int'(nat_out), int'(e.nat));
`endif
      end
    end
  end

  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    card1 = v.c1; card2 = v.c2; card3 = v.c3;
    exp_q.push_back(v);
  endtask

  // c1, c2, c3, total, bad, natural -- all hand-computed.
  vec_t vecs[16] = '{
    '{4'd2,  4'd3,  4'd1,  4'd6, 1'b0, 1'b0},
    '{4'd2,  4'd10, 4'd10, 4'd2, 1'b0, 1'b0},
    '{4'd10, 4'd10, 4'd11, 4'd0, 1'b0, 1'b0},
    '{4'd10, 4'd11, 4'd12, 4'd0, 1'b0, 1'b0},
    '{4'd2,  4'd11, 4'd12, 4'd2, 1'b0, 1'b0},
    '{4'd9,  4'd9,  4'd9,  4'd7, 1'b0, 1'b0},
    '{4'd9,  4'd8,  4'd0,  4'd7, 1'b0, 1'b0},
    '{4'd9,  4'd9,  4'd0,  4'd8, 1'b0, 1'b1},
    '{4'd15, 4'd5,  4'd0,  4'd5, 1'b1, 1'b0},
    '{4'd14, 4'd14, 4'd14, 4'd0, 1'b1, 1'b0},
    '{4'd4,  4'd4,  4'd0,  4'd8, 1'b0, 1'b1},
    '{4'd5,  4'd9,  4'd8,  4'd2, 1'b0, 1'b0},
    '{4'd1,  4'd13, 4'd7,  4'd8, 1'b0, 1'b0},
    '{4'd0,  4'd0,  4'd0,  4'd0, 1'b0, 1'b0},
    '{4'd6,  4'd3,  4'd0,  4'd9, 1'b0, 1'b1},
    '{4'd7,  4'd7,  4'd7,  4'd1, 1'b0, 1'b0}
  };

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    card1 = '0; card2 = '0; card3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_total", int'(total), 0);
    chk("reset_bad", int'(bad_card), 0);
    chk("reset_natural", int'(nat_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back stream.
    foreach (vecs[i]) drive(vecs[i]);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Idle: valid drops, result holds the last value (7,7,7 -> 1).
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_out_valid", int'(out_valid), 0);
    chk("idle_hold_total", int'(total), 1);

    // Non-zero result, then reset coincident with a valid input that must be dropped.
    drive('{4'd3, 4'd3, 4'd0, 4'd6, 1'b0, 1'b0});
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1;
    card1 = 4'd15; card2 = 4'd5; card3 = 4'd5;
    @(posedge clk);
    @(negedge clk);
    chk("rst_drop_out_valid", int'(out_valid), 0);
    chk("rst_drop_total", int'(total), 0);
    chk("rst_drop_bad", int'(bad_card), 0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;

    // First input after reset scores cleanly.
    drive('{4'd4, 4'd5, 4'd0, 4'd9, 1'b0, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
